// File: rtl/hostif_csr_pkg.sv
// hostif_csr_pkg
// Shared constants for the lightweight-bridge CSR responder. This package holds:
//   - the byte offsets of the registers and their 3-bit word selectors (address bits [4:2])
//   - the bit positions inside CTRL, STATUS and IRQ_PEND
//   - the word returned when the host pops an empty response FIFO
package hostif_csr_pkg;

  localparam logic [7:0] OFS_ID       = 8'h00;
  localparam logic [7:0] OFS_CTRL     = 8'h04;
  localparam logic [7:0] OFS_STATUS   = 8'h08;
  localparam logic [7:0] OFS_IRQ_PEND = 8'h0C;
  localparam logic [7:0] OFS_CMD_PUSH = 8'h10;
  localparam logic [7:0] OFS_RSP_POP  = 8'h14;
  localparam logic [7:0] OFS_SCRATCH  = 8'h18;
  localparam logic [7:0] OFS_RSVD     = 8'h1C;

  // Word selectors derived from the byte offsets; only address bits [4:2] are decoded.
  localparam logic [2:0] SEL_ID       = OFS_ID[4:2];
  localparam logic [2:0] SEL_CTRL     = OFS_CTRL[4:2];
  localparam logic [2:0] SEL_STATUS   = OFS_STATUS[4:2];
  localparam logic [2:0] SEL_IRQ_PEND = OFS_IRQ_PEND[4:2];
  localparam logic [2:0] SEL_CMD_PUSH = OFS_CMD_PUSH[4:2];
  localparam logic [2:0] SEL_RSP_POP  = OFS_RSP_POP[4:2];
  localparam logic [2:0] SEL_SCRATCH  = OFS_SCRATCH[4:2];
  localparam logic [2:0] SEL_RSVD     = OFS_RSVD[4:2];

  // CTRL bits
  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_CMD_FLUSH = 1;
  localparam int CTRL_RSP_FLUSH = 2;

  // STATUS bits and level fields
  localparam int ST_CMD_FULL    = 0;
  localparam int ST_CMD_EMPTY   = 1;
  localparam int ST_RSP_FULL    = 2;
  localparam int ST_RSP_EMPTY   = 3;
  localparam int ST_CMD_LVL_LSB = 8;
  localparam int ST_RSP_LVL_LSB = 16;

  // IRQ_PEND bits
  localparam int IRQ_RSP_AVAIL = 0;
  localparam int IRQ_CMD_OVF   = 1;
  localparam int IRQ_RSP_UNF   = 2;

  localparam logic [31:0] UNDERFLOW_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/hostif_sync_fifo.sv
// hostif_sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is visible on rdata whenever
// empty=0.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   push, wdata          write request and its data
//   pop                  read request
//   flush                empties the FIFO; it takes priority over push and pop in the
//                        same cycle
//   rdata                head word
//   full, empty, level   occupancy flags and count, where level runs 0..DEPTH
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only when a pop
// happens in the same cycle.
module hostif_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: state registers use non-blocking assignments so that every flop samples
  // pre-edge values, whatever order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Validity is tracked by the pointers and the
  // count alone, so the array can map onto RAM without a clear port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hostif_lw_csr_responder.sv
// hostif_lw_csr_responder
// Avalon-MM CSR responder on the HPS lightweight bridge. It gives the host:
//   - ID, CTRL, STATUS, IRQ_PEND and SCRATCH registers
//   - a host-to-fabric command FIFO, written through CMD_PUSH
//   - a fabric-to-host response FIFO, read through RSP_POP
//   - a level interrupt
// Ports:
//   clk100_clk, reset_clk100_reset_n   clock and synchronous active-low reset
//   avs_*                              Avalon-MM slave. Single beat, 32-bit data, read
//                                      latency of 1. Only address bits [4:2] are decoded.
//   irq_o                              irq_en & |IRQ_PEND, registered
//   cmd_data_o/cmd_valid_o/cmd_ready_i command FIFO head toward the fabric
//   rsp_data_i/rsp_valid_i/rsp_ready_o response words from the fabric
module hostif_lw_csr_responder
  import hostif_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h4D42_0001,
  parameter int          CMD_DEPTH = 16,
  parameter int          RSP_DEPTH = 16
) (
  input  logic        clk100_clk,
  input  logic        reset_clk100_reset_n,
  input  logic [17:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_burstcount,
  input  logic        avs_debugaccess,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        irq_o,
  output logic [31:0] cmd_data_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  input  logic [31:0] rsp_data_i,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o
);

  localparam int CLW = $clog2(CMD_DEPTH) + 1;
  localparam int RLW = $clog2(RSP_DEPTH) + 1;

  logic        waitreq_q;
  logic        irq_en_q;
  logic [2:0]  irq_pend_q;
  logic        irq_q;
  logic [31:0] scratch_q;
  logic        rdv_q;
  logic [31:0] rdata_q;

  logic [2:0]  sel;
  logic        wr_acc;
  logic        rd_acc;
  logic        cmd_flush;
  logic        rsp_flush;
  logic        cmd_push_req;
  logic        cmd_pop_req;
  logic        cmd_overflow;
  logic        rsp_push;
  logic        rsp_pop_rd;
  logic        rsp_underflow;
  logic [2:0]  pend_set;
  logic [2:0]  pend_clr;
  logic [31:0] rd_mux;

  logic [31:0]    cmd_head;
  logic           cmd_full;
  logic           cmd_empty;
  logic [CLW-1:0] cmd_level;
  logic [31:0]    rsp_head;
  logic           rsp_full;
  logic           rsp_empty;
  logic [RLW-1:0] rsp_level;

  logic unused_inputs;
  assign unused_inputs = ^{avs_address[17:5], avs_address[1:0], avs_burstcount, avs_debugaccess};

  // A write that comes with a read wins; the read half of that request is dropped.
  assign sel    = avs_address[4:2];
  assign wr_acc = avs_write & ~waitreq_q;
  assign rd_acc = avs_read & ~avs_write & ~waitreq_q;

  assign cmd_flush = wr_acc && (sel == SEL_CTRL) && avs_writedata[CTRL_CMD_FLUSH];
  assign rsp_flush = wr_acc && (sel == SEL_CTRL) && avs_writedata[CTRL_RSP_FLUSH];

  assign cmd_valid_o  = ~cmd_empty;
  assign cmd_data_o   = cmd_valid_o ? cmd_head : '0;
  assign cmd_push_req = wr_acc && (sel == SEL_CMD_PUSH);
  assign cmd_pop_req  = cmd_valid_o & cmd_ready_i;
  // A push to a full FIFO still lands when the fabric pops in the same cycle.
  assign cmd_overflow = cmd_push_req & cmd_full & ~cmd_pop_req;

  // Ready is held low while waitrequest is high, so that no response is taken in reset.
  assign rsp_ready_o   = ~rsp_full & ~waitreq_q;
  assign rsp_push      = rsp_valid_i & rsp_ready_o;
  assign rsp_pop_rd    = rd_acc && (sel == SEL_RSP_POP);
  assign rsp_underflow = rsp_pop_rd & rsp_empty;

  // A push that is discarded by a concurrent flush does not count as a response arrival.
  always_comb begin
    pend_set                = '0;
    pend_set[IRQ_RSP_AVAIL] = rsp_push & ~rsp_flush;
    pend_set[IRQ_CMD_OVF]   = cmd_overflow;
    pend_set[IRQ_RSP_UNF]   = rsp_underflow;
  end

  assign pend_clr = (wr_acc && (sel == SEL_IRQ_PEND)) ? avs_writedata[2:0] : 3'b000;

  hostif_sync_fifo #(.WIDTH(32), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk100_clk),
    .rst_n (reset_clk100_reset_n),
    .push  (cmd_push_req),
    .pop   (cmd_pop_req),
    .flush (cmd_flush),
    .wdata (avs_writedata),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .level (cmd_level)
  );

  hostif_sync_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk100_clk),
    .rst_n (reset_clk100_reset_n),
    .push  (rsp_push),
    .pop   (rsp_pop_rd),
    .flush (rsp_flush),
    .wdata (rsp_data_i),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .level (rsp_level)
  );

  // NOTE: every signal driven here gets a default first, so that no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_ID:       rd_mux = ID_VALUE;
      SEL_CTRL:     rd_mux[CTRL_IRQ_EN] = irq_en_q;
      SEL_STATUS: begin
        rd_mux[ST_CMD_FULL]              = cmd_full;
        rd_mux[ST_CMD_EMPTY]             = cmd_empty;
        rd_mux[ST_RSP_FULL]              = rsp_full;
        rd_mux[ST_RSP_EMPTY]             = rsp_empty;
        rd_mux[ST_CMD_LVL_LSB +: 8]      = 8'(cmd_level);
        rd_mux[ST_RSP_LVL_LSB +: 8]      = 8'(rsp_level);
      end
      SEL_IRQ_PEND: rd_mux[2:0] = irq_pend_q;
      SEL_CMD_PUSH: rd_mux = '0;
      SEL_RSP_POP:  rd_mux = rsp_empty ? UNDERFLOW_PATTERN : rsp_head;
      SEL_SCRATCH:  rd_mux = scratch_q;
      SEL_RSVD:     rd_mux = '0;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk100_clk) begin
    if (!reset_clk100_reset_n) begin
      waitreq_q  <= 1'b1;
      irq_en_q   <= 1'b0;
      irq_pend_q <= '0;
      irq_q      <= 1'b0;
      scratch_q  <= '0;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      waitreq_q <= 1'b0;
      if (wr_acc && (sel == SEL_CTRL)) irq_en_q <= avs_writedata[CTRL_IRQ_EN];
      // If a bit is set and cleared in the same cycle, the set wins.
      irq_pend_q <= (irq_pend_q & ~pend_clr) | pend_set;
      irq_q      <= irq_en_q & (|irq_pend_q);
      if (wr_acc && (sel == SEL_SCRATCH)) begin
        for (int i = 0; i < 4; i++) begin
          if (avs_byteenable[i]) scratch_q[8*i +: 8] <= avs_writedata[8*i +: 8];
        end
      end
      rdv_q   <= rd_acc;
      rdata_q <= rd_acc ? rd_mux : '0;
    end
  end

  assign avs_waitrequest   = waitreq_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;
  assign irq_o             = irq_q;

endmodule

// File: tb/tb_hostif_lw_csr_responder.sv
module tb_hostif_lw_csr_responder;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_burstcount;
  logic        avs_debugaccess;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq_o;
  logic [31:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [31:0] rsp_data_i;
  logic        rsp_valid_i;
  logic        rsp_ready_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_scratch = '0;

  always #5 clk = ~clk;

  hostif_lw_csr_responder dut (
    .clk100_clk           (clk),
    .reset_clk100_reset_n (rst_n),
    .avs_address          (avs_address),
    .avs_read             (avs_read),
    .avs_write            (avs_write),
    .avs_writedata        (avs_writedata),
    .avs_byteenable       (avs_byteenable),
    .avs_burstcount       (avs_burstcount),
    .avs_debugaccess      (avs_debugaccess),
    .avs_waitrequest      (avs_waitrequest),
    .avs_readdata         (avs_readdata),
    .avs_readdatavalid    (avs_readdatavalid),
    .irq_o                (irq_o),
    .cmd_data_o           (cmd_data_o),
    .cmd_valid_o          (cmd_valid_o),
    .cmd_ready_i          (cmd_ready_i),
    .rsp_data_i           (rsp_data_i),
    .rsp_valid_i          (rsp_valid_i),
    .rsp_ready_o          (rsp_ready_o)
  );

  // Expected STATUS word, built from the two FIFO occupancies.
  function automatic logic [31:0] exp_status(int nc, int nr);
    logic [31:0] s;
    s        = '0;
    s[0]     = (nc == D);
    s[1]     = (nc == 0);
    s[2]     = (nr == D);
    s[3]     = (nr == 0);
    s[15:8]  = 8'(nc);
    s[23:16] = 8'(nr);
    return s;
  endfunction

  // All helpers start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [31:0] d, input logic [3:0] be);
    avs_address    = {13'd0, sel, 2'b00};
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] sel, output logic [31:0] data, output logic vld);
    avs_address = {13'd0, sel, 2'b00};
    avs_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_read = 1'b0;
    vld      = avs_readdatavalid;
    data     = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    rst_n = 1'b0;
    idle(5);
    n_cmp++;
    if ({avs_waitrequest, avs_readdatavalid, avs_readdata, irq_o, cmd_valid_o, cmd_data_o, rsp_ready_o}
        !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: wr=%b rdv=%b rd=%h irq=%b cv=%b cd=%h rr=%b want wr=1, all others 0",
               avs_waitrequest, avs_readdatavalid, avs_readdata, irq_o, cmd_valid_o, cmd_data_o, rsp_ready_o);
    end
    rst_n = 1'b1;
    idle(1);
    n_cmp++;
    if (avs_waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL waitreq_release: got %b want 0", avs_waitrequest);
    end
    bus_read(3'd0, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 32'h4D42_0001}) begin
      n_bad++;
      $display("FAIL id_read: got v=%b d=%h want v=1 d=4d420001", v, d);
    end
    idle(1);
    n_cmp++;
    if ({avs_readdatavalid, avs_readdata} !== 33'd0) begin
      n_bad++;
      $display("FAIL rdv_idle: got v=%b d=%h want 0", avs_readdatavalid, avs_readdata);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic        v;
    logic [31:0] wd;
    logic [3:0]  be;
    bus_write(3'd6, 32'hAABBCCDD, 4'hF);
    bus_write(3'd6, 32'h11223344, 4'b0101);
    m_scratch = 32'hAA22CC44;
    bus_read(3'd6, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 32'hAA22CC44}) begin
      n_bad++;
      $display("FAIL scratch_lanes: got v=%b d=%h want v=1 d=aa22cc44", v, d);
    end
    for (int k = 0; k < 4; k++) begin
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      bus_write(3'd6, wd, be);
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
      bus_read(3'd6, d, v);
      n_cmp++;
      if ({v, d} !== {1'b1, m_scratch}) begin
        n_bad++;
        $display("FAIL scratch_rand%0d: got v=%b d=%h want d=%h", k, v, d, m_scratch);
      end
    end
  endtask

  task automatic test_cmd_fill_overflow();
    logic [31:0] d;
    logic        v;
    cmd_ready_i = 1'b0;
    for (int i = 1; i <= 17; i++) bus_write(3'd4, 32'(i), 4'hF);
    bus_read(3'd2, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, exp_status(16, 0)}) begin
      n_bad++;
      $display("FAIL fill_status: got v=%b d=%h want d=%h", v, d, exp_status(16, 0));
    end
    bus_read(3'd3, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 32'h2}) begin
      n_bad++;
      $display("FAIL overflow_pend: got v=%b d=%h want d=00000002", v, d);
    end
    cmd_ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if ({cmd_valid_o, cmd_data_o} !== {1'b1, 32'(i)}) begin
        n_bad++;
        $display("FAIL drain_word%0d: got v=%b d=%h want v=1 d=%h", i, cmd_valid_o, cmd_data_o, 32'(i));
      end
      idle(1);
    end
    n_cmp++;
    if ({cmd_valid_o, cmd_data_o} !== 33'd0) begin
      n_bad++;
      $display("FAIL drain_end: got v=%b d=%h want empty", cmd_valid_o, cmd_data_o);
    end
    cmd_ready_i = 1'b0;
    bus_write(3'd3, 32'h7, 4'hF);
  endtask

  task automatic test_rsp_irq();
    logic [31:0] d;
    logic        v;
    bus_write(3'd1, 32'h1, 4'hF);
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h0000_CAFE;
    n_cmp++;
    if (rsp_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rsp_ready: got %b want 1", rsp_ready_o);
    end
    idle(1);
    rsp_valid_i = 1'b0;
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_lat1: got %b want 0", irq_o);
    end
    idle(1);
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_lat2: got %b want 1", irq_o);
    end
    bus_read(3'd5, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 32'h0000_CAFE}) begin
      n_bad++;
      $display("FAIL rsp_pop: got v=%b d=%h want d=0000cafe", v, d);
    end
    bus_write(3'd3, 32'h1, 4'hF);
    idle(1);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_clear: got %b want 0", irq_o);
    end
    bus_read(3'd5, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL rsp_underflow_data: got v=%b d=%h want d=deadbeef", v, d);
    end
    bus_read(3'd3, d, v);
    n_cmp++;
    if ({v, d, irq_o} !== {1'b1, 32'h4, 1'b1}) begin
      n_bad++;
      $display("FAIL underflow_pend: got v=%b d=%h irq=%b want d=00000004 irq=1", v, d, irq_o);
    end
    bus_write(3'd3, 32'h7, 4'hF);
    bus_write(3'd1, 32'h0, 4'hF);
    idle(1);
  endtask

  task automatic test_flush_collision();
    logic [31:0] d;
    logic        v;
    for (int i = 0; i < 3; i++) bus_write(3'd4, $urandom, 4'hF);
    // The flush write and a fabric pop land on the same clock edge.
    cmd_ready_i    = 1'b1;
    avs_address    = {13'd0, 3'd1, 2'b00};
    avs_writedata  = 32'h2;
    avs_byteenable = 4'hF;
    avs_write      = 1'b1;
    idle(1);
    avs_write   = 1'b0;
    cmd_ready_i = 1'b0;
    n_cmp++;
    if (cmd_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL cmd_flush_valid: got %b want 0", cmd_valid_o);
    end
    bus_read(3'd2, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, exp_status(0, 0)}) begin
      n_bad++;
      $display("FAIL cmd_flush_status: got v=%b d=%h want d=%h", v, d, exp_status(0, 0));
    end
    bus_write(3'd4, 32'h0000_0055, 4'hF);
    n_cmp++;
    if ({cmd_valid_o, cmd_data_o} !== {1'b1, 32'h55}) begin
      n_bad++;
      $display("FAIL after_flush_push: got v=%b d=%h want v=1 d=00000055", cmd_valid_o, cmd_data_o);
    end
    bus_write(3'd1, 32'h2, 4'hF);
    // A response flush discards a response pushed in the same cycle.
    rsp_valid_i = 1'b1;
    rsp_data_i  = $urandom;
    idle(2);
    rsp_data_i     = $urandom;
    avs_address    = {13'd0, 3'd1, 2'b00};
    avs_writedata  = 32'h4;
    avs_write      = 1'b1;
    idle(1);
    avs_write   = 1'b0;
    rsp_valid_i = 1'b0;
    bus_read(3'd2, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, exp_status(0, 0)}) begin
      n_bad++;
      $display("FAIL rsp_flush_status: got v=%b d=%h want d=%h", v, d, exp_status(0, 0));
    end
    bus_write(3'd3, 32'h7, 4'hF);
  endtask

  task automatic test_random();
    logic [31:0] cq[$];
    logic [31:0] rq[$];
    logic        en;
    logic [2:0]  pend;
    logic        exp_rdv;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        exp_irq_next;
    logic [32:0] exp_cmd;
    logic        do_wr, do_rd, cready, rvalid;
    logic [2:0]  sel;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        flush_c, flush_r, c_pop, c_push_wr, c_push, ovf, r_push, r_pop, unf;
    int          r;
    int          nc, nr;
    bus_write(3'd1, 32'h6, 4'hF);
    bus_write(3'd3, 32'h7, 4'hF);
    idle(2);
    en = 1'b0; pend = '0; exp_rdv = 1'b0; exp_rd = '0; exp_irq = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++;
      if ({avs_readdatavalid, avs_readdata} !== {exp_rdv, exp_rd}) begin
        n_bad++;
        $display("FAIL rand_read c%0d: got v=%b d=%h want v=%b d=%h", cyc, avs_readdatavalid, avs_readdata, exp_rdv, exp_rd);
      end
      n_cmp++;
      if (irq_o !== exp_irq) begin
        n_bad++;
        $display("FAIL rand_irq c%0d: got %b want %b", cyc, irq_o, exp_irq);
      end
      exp_cmd = (cq.size() > 0) ? {1'b1, cq[0]} : 33'd0;
      n_cmp++;
      if ({cmd_valid_o, cmd_data_o} !== exp_cmd) begin
        n_bad++;
        $display("FAIL rand_cmd_head c%0d: got v=%b d=%h want %h", cyc, cmd_valid_o, cmd_data_o, exp_cmd);
      end
      n_cmp++;
      if (rsp_ready_o !== (rq.size() < D)) begin
        n_bad++;
        $display("FAIL rand_rsp_ready c%0d: got %b level %0d", cyc, rsp_ready_o, rq.size());
      end

      r      = int'($urandom_range(0, 9));
      do_wr  = (r <= 3) || (r == 8);
      do_rd  = (r >= 4) && (r <= 8);
      sel    = (r <= 1) ? 3'd4 : 3'($urandom_range(0, 7));
      wd     = $urandom;
      be     = 4'($urandom_range(0, 15));
      if (sel == 3'd1 && $urandom_range(0, 7) != 0) wd[2:1] = 2'b00;
      cready = 1'($urandom_range(0, 1));
      rvalid = ($urandom_range(0, 2) == 0);
      avs_address    = {13'd0, sel, 2'b00};
      avs_write      = do_wr;
      avs_read       = do_rd;
      avs_writedata  = wd;
      avs_byteenable = be;
      cmd_ready_i    = cready;
      rsp_valid_i    = rvalid;
      rsp_data_i     = $urandom;

      nc        = cq.size();
      nr        = rq.size();
      do_rd     = do_rd & ~do_wr;
      flush_c   = do_wr && sel == 3'd1 && wd[1];
      flush_r   = do_wr && sel == 3'd1 && wd[2];
      c_pop     = cready && nc > 0;
      c_push_wr = do_wr && sel == 3'd4;
      c_push    = c_push_wr && (nc < D || c_pop);
      ovf       = c_push_wr && !c_push;
      r_push    = rvalid && nr < D;
      r_pop     = do_rd && sel == 3'd5 && nr > 0;
      unf       = do_rd && sel == 3'd5 && nr == 0;

      exp_irq_next = en & (|pend);
      exp_rdv      = do_rd;
      exp_rd       = '0;
      if (do_rd) begin
        case (sel)
          3'd0: exp_rd = 32'h4D42_0001;
          3'd1: exp_rd = {31'd0, en};
          3'd2: exp_rd = exp_status(nc, nr);
          3'd3: exp_rd = {29'd0, pend};
          3'd5: exp_rd = (nr > 0) ? rq[0] : 32'hDEAD_BEEF;
          3'd6: exp_rd = m_scratch;
          default: exp_rd = '0;
        endcase
      end

      pend = (pend & ((do_wr && sel == 3'd3) ? ~wd[2:0] : 3'b111))
             | {unf, ovf, r_push && !flush_r};
      if (do_wr && sel == 3'd1) en = wd[0];
      if (do_wr && sel == 3'd6)
        for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
      if (flush_c) cq.delete();
      else begin
        if (c_pop)  void'(cq.pop_front());
        if (c_push) cq.push_back(wd);
      end
      if (flush_r) rq.delete();
      else begin
        if (r_pop)  void'(rq.pop_front());
        if (r_push) rq.push_back(rsp_data_i);
      end

      idle(1);
      exp_irq = exp_irq_next;
    end
    avs_write   = 1'b0;
    avs_read    = 1'b0;
    cmd_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic        v;
    bus_write(3'd4, 32'h1234, 4'hF);
    bus_write(3'd6, 32'h5A5A_5A5A, 4'hF);
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h77;
    idle(1);
    rsp_valid_i = 1'b0;
    // The read is presented in the same cycle that reset is sampled low.
    avs_address = {13'd0, 3'd2, 2'b00};
    avs_read    = 1'b1;
    rst_n       = 1'b0;
    idle(1);
    avs_read = 1'b0;
    n_cmp++;
    if ({avs_readdatavalid, avs_waitrequest} !== 2'b01) begin
      n_bad++;
      $display("FAIL midread_cancel: got rdv=%b wr=%b want rdv=0 wr=1", avs_readdatavalid, avs_waitrequest);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      n_cmp++;
      if (avs_readdatavalid !== 1'b0) begin
        n_bad++;
        $display("FAIL midread_hold%0d: got rdv=%b want 0", i, avs_readdatavalid);
      end
    end
    rst_n = 1'b1;
    idle(1);
    n_cmp++;
    if ({avs_waitrequest, cmd_valid_o, rsp_ready_o, irq_o} !== 4'b0010) begin
      n_bad++;
      $display("FAIL after_reset_flags: got wr=%b cv=%b rr=%b irq=%b want 0 0 1 0",
               avs_waitrequest, cmd_valid_o, rsp_ready_o, irq_o);
    end
    bus_read(3'd2, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, exp_status(0, 0)}) begin
      n_bad++;
      $display("FAIL after_reset_status: got v=%b d=%h want d=%h", v, d, exp_status(0, 0));
    end
    bus_read(3'd6, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL after_reset_scratch: got v=%b d=%h want d=0", v, d);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    avs_address     = '0;
    avs_read        = 1'b0;
    avs_write       = 1'b0;
    avs_writedata   = '0;
    avs_byteenable  = 4'hF;
    avs_burstcount  = 1'b1;
    avs_debugaccess = 1'b0;
    cmd_ready_i     = 1'b0;
    rsp_data_i      = '0;
    rsp_valid_i     = 1'b0;
    @(negedge clk);
    test_reset();
    test_scratch();
    test_cmd_fill_overflow();
    test_rsp_irq();
    test_flush_collision();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
